// File: rtl/sdram_request_port_if.sv
// rtl/sdram_request_port_if.sv - request, read-return and controller-side signals of the SDRAM client port
interface sdram_request_port_if;
    logic        Req_Valid;
    logic        Req_Ready;
    logic        Req_WE;
    logic [24:0] Req_Addr;
    logic [15:0] Req_Wdata;
    logic        Rd_Valid;
    logic [15:0] Rd_Data;
    logic        Busy;
    logic [24:0] Mem_Addr;
    logic [15:0] Mem_Din;
    logic        Mem_WE;
    logic        Mem_Focus;
    logic        Mem_R;
    logic [15:0] Mem_Dout;

    modport slave (
        input  Req_Valid, Req_WE, Req_Addr, Req_Wdata, Mem_R, Mem_Dout,
        output Req_Ready, Rd_Valid, Rd_Data, Busy, Mem_Addr, Mem_Din, Mem_WE, Mem_Focus
    );

    modport master (
        output Req_Valid, Req_WE, Req_Addr, Req_Wdata, Mem_R, Mem_Dout,
        input  Req_Ready, Rd_Valid, Rd_Data, Busy, Mem_Addr, Mem_Din, Mem_WE, Mem_Focus
    );
endinterface

// File: rtl/sdram_request_port.sv
// rtl/sdram_request_port.sv - FIFO-buffered request port presenting one request at a time to sdram_controller
module sdram_request_port #(
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 3,
    parameter int FOCUS_LIMIT  = 64
) (
    input  logic               Clk,
    input  logic               Reset_n,
    sdram_request_port_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = $clog2(FOCUS_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    logic [41:0]             fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CW-1:0]           count, count_nxt;
    logic [41:0]             next_head;
    logic                    pres_we;
    logic [24:0]             pres_addr;
    logic [15:0]             pres_din;
    logic                    bubble;
    logic [READ_LATENCY-1:0] rd_pipe;
    logic [FW-1:0]           focus_cnt;
    logic                    head_valid, pipe_empty, push, fire, read_fire;
    state_t                  state;

    assign head_valid    = (count != '0);
    assign pipe_empty    = (rd_pipe == '0);
    assign bus.Req_Ready = (count != CW'(FIFO_DEPTH));
    assign push          = bus.Req_Valid & bus.Req_Ready;

    // A write waits for the read pipe to drain so DQ is never driven while read data returns.
    assign fire      = head_valid & ~bubble & bus.Mem_R & (~pres_we | pipe_empty);
    assign read_fire = fire & ~pres_we;

    assign bus.Mem_WE    = head_valid & pres_we & pipe_empty & ~bubble;
    assign bus.Mem_Focus = head_valid & (focus_cnt < FW'(FOCUS_LIMIT));
    assign bus.Mem_Addr  = pres_addr;
    assign bus.Mem_Din   = pres_din;

    assign count_nxt  = count + CW'(push) - CW'(fire);
    assign rd_ptr_nxt = rd_ptr + PW'(fire);

    // The slot becoming the head may be the one written on this same edge.
    assign next_head = (push && (wr_ptr == rd_ptr_nxt)) ?
                       {bus.Req_WE, bus.Req_Addr, bus.Req_Wdata} : fifo_mem[rd_ptr_nxt];

    always_ff @(posedge Clk) begin
        if (push) fifo_mem[wr_ptr] <= {bus.Req_WE, bus.Req_Addr, bus.Req_Wdata};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            bubble       <= 1'b0;
            pres_we      <= 1'b0;
            pres_addr    <= '0;
            pres_din     <= '0;
            rd_pipe      <= '0;
            focus_cnt    <= '0;
            bus.Rd_Valid <= 1'b0;
            bus.Rd_Data  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            bubble <= fire;
            // An empty FIFO leaves the last address presented so the open row is kept.
            if (count_nxt != '0) begin
                pres_we   <= next_head[41];
                pres_addr <= next_head[40:16];
                pres_din  <= next_head[41] ? next_head[15:0] : 16'h0000;
            end
            rd_pipe      <= (rd_pipe << 1) | READ_LATENCY'(read_fire);
            bus.Rd_Valid <= rd_pipe[READ_LATENCY-1];
            if (rd_pipe[READ_LATENCY-1]) bus.Rd_Data <= bus.Mem_Dout;
            // Focus low with R low means the controller left RW mode, i.e. took its refresh.
            if (!head_valid || (!bus.Mem_Focus && !bus.Mem_R))
                focus_cnt <= '0;
            else if (bus.Mem_Focus)
                focus_cnt <= focus_cnt + FW'(1);
        end
    end

    always_comb begin
        state = IDLE;
        if (head_valid)       state = ISSUE;
        else if (!pipe_empty) state = DRAIN;
    end

    assign bus.Busy = (state != IDLE);
endmodule
